// File: rtl/id_stage_pkg.sv
// rtl/id_stage_pkg.sv - opcode constants and immediate-format encoding for the decode stage
package id_stage_pkg;

  // RV32I major opcodes recognised by the decoder
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  // Immediate layout selector; IMM_NONE yields a zero immediate (R-type, illegal)
  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - RV32I immediate assembly and sign extension
module imm_gen
  import id_stage_pkg::*;
(
  input  logic [31:7] instr,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  // Reassemble the scattered immediate bits for the selected format, sign bit is always instr[31]
  always_comb begin
    imm = '0;
    case (fmt)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// rtl/id_stage.sv - RV32I decode stage with writeback bypass, load-use interlock and ID/EX register
module id_stage
  import id_stage_pkg::*;
#(
  parameter int width  = 32,
  parameter int regsel = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [width-1:0]  in_instr,
  input  logic [width-1:0]  in_pc,
  input  logic              flush,
  output logic [regsel-1:0] rf_rs1,
  output logic [regsel-1:0] rf_rs2,
  output logic              rf_rs1v,
  output logic              rf_rs2v,
  input  logic [width-1:0]  rf_dataA,
  input  logic [width-1:0]  rf_dataB,
  input  logic              wb_we,
  input  logic [regsel-1:0] wb_rd,
  input  logic [width-1:0]  wb_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [width-1:0]  out_pc,
  output logic [width-1:0]  out_a,
  output logic [width-1:0]  out_b,
  output logic [width-1:0]  out_imm,
  output logic [regsel-1:0] out_rd,
  output logic              out_rd_we,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic              out_f7b5,
  output logic              out_is_load,
  output logic              out_illegal
);

  logic [6:0]        opcode;
  logic [regsel-1:0] rs1;
  logic [regsel-1:0] rs2;
  logic [regsel-1:0] rd;
  logic              uses_rs1;
  logic              uses_rs2;
  logic              writes_rd;
  logic              is_load;
  logic              illegal;
  imm_fmt_e          fmt;
  logic [width-1:0]  imm;
  logic [width-1:0]  opnd_a;
  logic [width-1:0]  opnd_b;
  logic              hazard;
  logic              adv;

  assign opcode = in_instr[6:0];
  assign rd     = in_instr[11:7];
  assign rs1    = in_instr[19:15];
  assign rs2    = in_instr[24:20];

  // Classify the opcode: which sources are read, whether rd is written, immediate layout
  always_comb begin
    uses_rs1  = 1'b0;
    uses_rs2  = 1'b0;
    writes_rd = 1'b0;
    is_load   = 1'b0;
    illegal   = 1'b0;
    fmt       = IMM_NONE;
    case (opcode)
      OP_R:      begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; writes_rd = 1'b1; end
      OP_IMM:    begin uses_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I; end
      OP_LOAD:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; is_load = 1'b1; fmt = IMM_I; end
      OP_STORE:  begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_S; end
      OP_BRANCH: begin uses_rs1 = 1'b1; uses_rs2 = 1'b1; fmt = IMM_B; end
      OP_JAL:    begin writes_rd = 1'b1; fmt = IMM_J; end
      OP_JALR:   begin uses_rs1 = 1'b1; writes_rd = 1'b1; fmt = IMM_I; end
      OP_LUI:    begin writes_rd = 1'b1; fmt = IMM_U; end
      OP_AUIPC:  begin writes_rd = 1'b1; fmt = IMM_U; end
      default:   illegal = 1'b1;
    endcase
  end

  imm_gen u_imm_gen (
    .instr (in_instr[31:7]),
    .fmt   (fmt),
    .imm   (imm)
  );

  assign rf_rs1  = rs1;
  assign rf_rs2  = rs2;
  assign rf_rs1v = in_valid && uses_rs1;
  assign rf_rs2v = in_valid && uses_rs2;

  // Operand select: x0 reads as zero, otherwise the writeback in flight wins over the file
  always_comb begin
    opnd_a = rf_dataA;
    opnd_b = rf_dataB;
    if (rs1 == '0)
      opnd_a = '0;
    else if (wb_we && (wb_rd == rs1))
      opnd_a = wb_data;
    if (rs2 == '0)
      opnd_b = '0;
    else if (wb_we && (wb_rd == rs2))
      opnd_b = wb_data;
  end

  // A load held in ID/EX cannot forward its data to a consumer decoding right now
  assign hazard = out_valid && out_is_load && (out_rd != '0) &&
                  ((rf_rs1v && (rs1 == out_rd)) || (rf_rs2v && (rs2 == out_rd)));
  assign adv      = !out_valid || out_ready;
  assign in_ready = adv && !hazard;

  // ID/EX pipeline register: flush kills, hazard bubbles, stall holds
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      out_pc      <= '0;
      out_a       <= '0;
      out_b       <= '0;
      out_imm     <= '0;
      out_rd      <= '0;
      out_rd_we   <= 1'b0;
      out_opcode  <= '0;
      out_funct3  <= '0;
      out_f7b5    <= 1'b0;
      out_is_load <= 1'b0;
      out_illegal <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (adv) begin
      if (hazard) begin
        out_valid <= 1'b0;
      end else begin
        out_valid <= in_valid;
        if (in_valid) begin
          out_pc      <= in_pc;
          out_a       <= opnd_a;
          out_b       <= opnd_b;
          out_imm     <= imm;
          out_rd      <= rd;
          out_rd_we   <= writes_rd && !illegal && (rd != '0);
          out_opcode  <= opcode;
          out_funct3  <= in_instr[14:12];
          out_f7b5    <= in_instr[30];
          out_is_load <= is_load;
          out_illegal <= illegal;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed self-checking bench for id_stage
module tb_id_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic [4:0]  rf_rs1;
  logic [4:0]  rf_rs2;
  logic        rf_rs1v;
  logic        rf_rs2v;
  logic [31:0] rf_dataA;
  logic [31:0] rf_dataB;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [31:0] out_imm;
  logic [4:0]  out_rd;
  logic        out_rd_we;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic        out_f7b5;
  logic        out_is_load;
  logic        out_illegal;

  int tests = 0;
  int fails = 0;

  id_stage dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .flush       (flush),
    .rf_rs1      (rf_rs1),
    .rf_rs2      (rf_rs2),
    .rf_rs1v     (rf_rs1v),
    .rf_rs2v     (rf_rs2v),
    .rf_dataA    (rf_dataA),
    .rf_dataB    (rf_dataB),
    .wb_we       (wb_we),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_pc      (out_pc),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_imm     (out_imm),
    .out_rd      (out_rd),
    .out_rd_we   (out_rd_we),
    .out_opcode  (out_opcode),
    .out_funct3  (out_funct3),
    .out_f7b5    (out_f7b5),
    .out_is_load (out_is_load),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] rfa;
    logic [31:0] rfb;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [31:0] e_a;
    logic [31:0] e_b;
    logic [31:0] e_imm;
    logic [4:0]  e_rd;
    logic        e_we;
    logic        e_load;
    logic        e_ill;
    logic        e_rs1v;
    logic        e_rs2v;
  } vec_t;

  localparam int NVEC = 11;
  vec_t vecs [NVEC];

  function automatic vec_t mk(
    input logic [31:0] instr, input logic [31:0] rfa, input logic [31:0] rfb,
    input logic wbwe, input logic [4:0] wbrd, input logic [31:0] wbd,
    input logic [31:0] ea, input logic [31:0] eb, input logic [31:0] eimm,
    input logic [4:0] erd, input logic ewe, input logic eld, input logic eill,
    input logic ev1, input logic ev2);
    vec_t v;
    v.instr = instr; v.rfa = rfa; v.rfb = rfb;
    v.wb_we = wbwe; v.wb_rd = wbrd; v.wb_data = wbd;
    v.e_a = ea; v.e_b = eb; v.e_imm = eimm; v.e_rd = erd;
    v.e_we = ewe; v.e_load = eld; v.e_ill = eill; v.e_rs1v = ev1; v.e_rs2v = ev2;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    logic [31:0] ins;

    //              instr         rfa           rfb           we wrd    wb_data       a             b             imm           rd  we ld il v1 v2
    vecs[0]  = mk(32'hFFF00293, 32'h1234,     32'h5678,     0, 5'd0, 32'h0,      32'h0,     32'h5678,  32'hFFFFFFFF, 5'd5,  1, 0, 0, 1, 0); // addi x5,x0,-1
    vecs[1]  = mk(32'h002081B3, 32'd7,        32'd9,        1, 5'd2, 32'h55,     32'd7,     32'h55,    32'h0,        5'd3,  1, 0, 0, 1, 1); // add x3,x1,x2
    vecs[2]  = mk(32'h7E20AE23, 32'h100,      32'hABCD,     0, 5'd0, 32'h0,      32'h100,   32'hABCD,  32'h7FC,      5'd28, 0, 0, 0, 1, 1); // sw x2,0x7fc(x1)
    vecs[3]  = mk(32'hFE208EE3, 32'h3,        32'h3,        1, 5'd1, 32'hBEEF,   32'hBEEF,  32'h3,     32'hFFFFFFFC, 5'd29, 0, 0, 0, 1, 1); // beq x1,x2,-4
    vecs[4]  = mk(32'h123453B7, 32'h11,       32'h22,       0, 5'd0, 32'h0,      32'h11,    32'h22,    32'h12345000, 5'd7,  1, 0, 0, 0, 0); // lui x7
    vecs[5]  = mk(32'h001000EF, 32'h44,       32'h55,       0, 5'd0, 32'h0,      32'h0,     32'h55,    32'h800,      5'd1,  1, 0, 0, 0, 0); // jal x1,2048
    vecs[6]  = mk(32'h004280E7, 32'h66,       32'h77,       0, 5'd0, 32'h0,      32'h66,    32'h77,    32'h4,        5'd1,  1, 0, 0, 1, 0); // jalr x1,4(x5)
    vecs[7]  = mk(32'hFFFFF517, 32'h88,       32'h99,       0, 5'd0, 32'h0,      32'h88,    32'h99,    32'hFFFFF000, 5'd10, 1, 0, 0, 0, 0); // auipc x10
    vecs[8]  = mk(32'h0000007F, 32'h12,       32'h34,       0, 5'd0, 32'h0,      32'h0,     32'h0,     32'h0,        5'd0,  0, 0, 1, 0, 0); // illegal
    vecs[9]  = mk(32'h00100013, 32'h99,       32'h33,       1, 5'd0, 32'hDEAD,   32'h0,     32'h33,    32'h1,        5'd0,  0, 0, 0, 1, 0); // addi x0,x0,1
    vecs[10] = mk(32'hFF80A203, 32'h1000,     32'h2000,     0, 5'd0, 32'h0,      32'h1000,  32'h2000,  32'hFFFFFFF8, 5'd4,  1, 1, 0, 1, 0); // lw x4,-8(x1)

    rst = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0;
    rf_dataA = '0; rf_dataB = '0; wb_we = 1'b0; wb_rd = '0; wb_data = '0; out_ready = 1'b1;

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'h0);
    chk("rst_out_imm", out_imm, 32'h0);
    chk("rst_out_pc", out_pc, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h1);
    rst = 1'b1;

    // Table: one instruction per cycle, EX always ready, no load-use dependences
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      ins      = vecs[i].instr;
      in_valid = 1'b1;
      in_instr = ins;
      in_pc    = 32'h1000 + 32'(i * 4);
      rf_dataA = vecs[i].rfa;
      rf_dataB = vecs[i].rfb;
      wb_we    = vecs[i].wb_we;
      wb_rd    = vecs[i].wb_rd;
      wb_data  = vecs[i].wb_data;
      #1;
      chk($sformatf("v%0d_in_ready", i), {31'b0, in_ready}, 32'h1);
      chk($sformatf("v%0d_rs1v", i), {31'b0, rf_rs1v}, {31'b0, vecs[i].e_rs1v});
      chk($sformatf("v%0d_rs2v", i), {31'b0, rf_rs2v}, {31'b0, vecs[i].e_rs2v});
      chk($sformatf("v%0d_rs1", i), {27'b0, rf_rs1}, {27'b0, ins[19:15]});
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), {31'b0, out_valid}, 32'h1);
      chk($sformatf("v%0d_a", i), out_a, vecs[i].e_a);
      chk($sformatf("v%0d_b", i), out_b, vecs[i].e_b);
      chk($sformatf("v%0d_imm", i), out_imm, vecs[i].e_imm);
      chk($sformatf("v%0d_rd", i), {27'b0, out_rd}, {27'b0, vecs[i].e_rd});
      chk($sformatf("v%0d_rd_we", i), {31'b0, out_rd_we}, {31'b0, vecs[i].e_we});
      chk($sformatf("v%0d_is_load", i), {31'b0, out_is_load}, {31'b0, vecs[i].e_load});
      chk($sformatf("v%0d_illegal", i), {31'b0, out_illegal}, {31'b0, vecs[i].e_ill});
      chk($sformatf("v%0d_pc", i), out_pc, 32'h1000 + 32'(i * 4));
      chk($sformatf("v%0d_opcode", i), {25'b0, out_opcode}, {25'b0, ins[6:0]});
      chk($sformatf("v%0d_funct3", i), {29'b0, out_funct3}, {29'b0, ins[14:12]});
    end

    // Load-use: lw x4 then add x6,x4,x4 costs one bubble
    @(negedge clk);
    wb_we = 1'b0; rst = 1'b0;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h0000A203;
    @(posedge clk); #1;
    chk("lu_lw_valid", {31'b0, out_valid}, 32'h1);
    @(negedge clk);
    in_instr = 32'h00420333; rf_dataA = 32'h40; rf_dataB = 32'h41; #1;
    chk("lu_in_ready_low", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("lu_bubble", {31'b0, out_valid}, 32'h0);
    @(negedge clk); #1;
    chk("lu_in_ready_high", {31'b0, in_ready}, 32'h1);
    @(posedge clk); #1;
    chk("lu_add_valid", {31'b0, out_valid}, 32'h1);
    chk("lu_add_rd", {27'b0, out_rd}, 32'd6);
    chk("lu_add_a", out_a, 32'h40);

    // Dependent load after load: one bubble, then the second load issues
    @(negedge clk);
    in_instr = 32'h0000A203;
    @(posedge clk);
    @(negedge clk);
    in_instr = 32'h00022283; #1;
    chk("ll_in_ready_low", {31'b0, in_ready}, 32'h0);
    @(posedge clk); #1;
    chk("ll_bubble", {31'b0, out_valid}, 32'h0);
    @(posedge clk); #1;
    chk("ll_valid", {31'b0, out_valid}, 32'h1);
    chk("ll_rd", {27'b0, out_rd}, 32'd5);
    chk("ll_is_load", {31'b0, out_is_load}, 32'h1);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("drain_valid", {31'b0, out_valid}, 32'h0);

    // Stall: sw held three cycles while EX is not ready
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'h7E20AE23; rf_dataA = 32'h100; rf_dataB = 32'hABCD;
    @(posedge clk); #1;
    chk("st_sw_imm", out_imm, 32'h7FC);
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'hFFF00293; rf_dataB = 32'h0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk($sformatf("st%0d_in_ready", c), {31'b0, in_ready}, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("st%0d_valid", c), {31'b0, out_valid}, 32'h1);
      chk($sformatf("st%0d_imm", c), out_imm, 32'h7FC);
      chk($sformatf("st%0d_b", c), out_b, 32'hABCD);
      chk($sformatf("st%0d_opcode", c), {25'b0, out_opcode}, 32'h23);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("st_release_rd", {27'b0, out_rd}, 32'd5);
    chk("st_release_imm", out_imm, 32'hFFFFFFFF);

    // Flush while a beq is held and a new instruction is presented
    @(negedge clk);
    in_instr = 32'hFE208EE3;
    @(posedge clk); #1;
    chk("fl_beq_opcode", {25'b0, out_opcode}, 32'h63);
    @(negedge clk);
    out_ready = 1'b0; in_instr = 32'hFFF00293; flush = 1'b1;
    @(posedge clk); #1;
    chk("fl_valid", {31'b0, out_valid}, 32'h0);
    chk("fl_not_accepted", {25'b0, out_opcode}, 32'h63);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("fl_after_valid", {31'b0, out_valid}, 32'h0);

    // Asynchronous reset while stalled discards the held instruction
    @(negedge clk);
    in_valid = 1'b1; in_instr = 32'hFFF00293;
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chk("rs_held_valid", {31'b0, out_valid}, 32'h1);
    #2 rst = 1'b0; #1;
    chk("rs_valid", {31'b0, out_valid}, 32'h0);
    chk("rs_rd", {27'b0, out_rd}, 32'h0);
    chk("rs_imm", out_imm, 32'h0);
    chk("rs_in_ready", {31'b0, in_ready}, 32'h1);
    @(negedge clk);
    rst = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/id_stage.md
Name: id_stage

Overview:
- Instruction-decode stage directly upstream of the 32-entry register file; it feeds the file's read-select ports and consumes its combinational read data.
- Decodes one RV32I instruction per handshake and drives rs1/rs2 plus their valid strobes into the register file.
- Applies writeback bypass and load-use interlock, then registers the operands, immediate and control into the ID/EX pipeline register.

Parameters:
- width, 32, datapath and instruction width
- regsel, 5, register-select width

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous and active-low; clears all state
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  stage accepts in_instr this cycle
- in_instr  in  width  instruction word
- in_pc  in  width  instruction address
- flush  in  1  kill the held output and the instruction being accepted
- rf_rs1  out  regsel  register-file read select A
- rf_rs2  out  regsel  register-file read select B
- rf_rs1v  out  1  register-file read enable A
- rf_rs2v  out  1  register-file read enable B
- rf_dataA  in  width  register-file read data A
- rf_dataB  in  width  register-file read data B
- wb_we  in  1  writeback write enable (same strobe the register file sees)
- wb_rd  in  regsel  writeback destination
- wb_data  in  width  writeback data
- out_valid  out  1  ID/EX register holds a valid instruction
- out_ready  in  1  EX consumes it
- out_pc  out  width  registered pc
- out_a  out  width  registered rs1 operand
- out_b  out  width  registered rs2 operand
- out_imm  out  width  registered sign-extended immediate
- out_rd  out  regsel  destination register
- out_rd_we  out  1  instruction writes rd (forced 0 when rd==0)
- out_opcode  out  7  opcode
- out_funct3  out  3  funct3
- out_f7b5  out  1  instr[30]
- out_is_load  out  1  opcode 0000011
- out_illegal  out  1  unrecognised opcode

Behaviour:
- Reset (rst low, async): out_valid=0 and every out_* register=0. in_ready is then combinationally 1.
- Decode is combinational from in_instr:
  - rf_rs1=instr[19:15], rf_rs2=instr[24:20].
  - rf_rs1v=1 for R/I/S/B/JALR/load formats.
  - rf_rs2v=1 for R/S/B formats.
  - Both enables are gated by in_valid.
- Immediate selection:
  - I: instr[31:20]
  - S: {31:25,11:7}
  - B: {31,7,30:25,11:8,0}
  - U: {31:12,12'b0}
  - J: {31,19:12,20,30:21,0}
  - All sign-extended from instr[31]; R-type imm=0.
- Opcodes: 0110011, 0010011, 0000011, 0100011, 1100011, 1101111, 1100111, 0110111, 0010111. Anything else sets out_illegal=1 with out_rd_we=0; the instruction still flows.
- Bypass: operand A = (wb_we && wb_rd==rs1 && rs1!=0) ? wb_data : rf_dataA; same rule for B. rs==0 always yields 0, regardless of rf data.
- Load-use interlock: hazard = out_valid && out_is_load && out_rd!=0 && ((rf_rs1v && rs1==out_rd) || (rf_rs2v && rs2==out_rd)).
- Advance condition: adv = !out_valid || out_ready.
- in_ready = adv && !hazard.
- Output register update on each clk edge:
  - flush: out_valid<=0; input not accepted (in_ready is ignored this cycle).
  - else adv && hazard: out_valid<=0 (bubble). The input is held, re-read next cycle.
  - else adv: out_valid<=in_valid; load the payload when in_valid.
  - else: hold all outputs (stall).
- Latency: one cycle from accept to out_valid.
- Throughput: 1/cycle with no hazard. A load-use costs exactly one bubble.
- A back-to-back dependent load→load inserts one bubble, then proceeds.
- Outputs are held stable while out_valid && !out_ready.
- Reset mid-stall discards the held instruction.

Decomposition:
- Shared package: opcode constants (OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC) and immediate-format encoding.
- One sub-module, imm_gen: combinational format select plus sign extension, reused by later stages.

Test Plan:
- Reset then `addi x5,x0,-1` (0xFFF00293) with in_valid=1, out_ready=1 -> next cycle out_valid=1, out_imm=0xFFFFFFFF, out_rd=5, out_rd_we=1, out_a=0.
- `add x3,x1,x2` with rf_dataA=7, rf_dataB=9, wb_we=1, wb_rd=2, wb_data=0x55 -> out_a=7, out_b=0x55.
- `lw x4,0(x1)` then `add x6,x4,x4` -> cycle after the lw: in_ready=0; next out_valid=0 (bubble); add is issued the following cycle.
- out_ready=0 for 3 cycles while holding a `sw` (imm 0x7FC) -> all out_* unchanged, in_ready=0; release -> next instruction accepted.
- flush asserted while a `beq` is held and a new instruction is presented -> out_valid=0 next cycle; the presented instruction is not accepted.
- Opcode 0x7F -> out_illegal=1, out_rd_we=0. Also `addi x0,x0,1` -> out_rd_we=0, and rd==0 bypass ignored.
